// File: rtl/sysid_pkg.sv
// Shared definitions for the system-identification register bank.
// Holds the word address map and the CONTROL register bit positions so the
// top level, the uptime counter and any software-facing test code agree on
// one set of constants.
package sysid_pkg;

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TS      = 3'd1;
    localparam logic [2:0] ADDR_VER     = 3'd2;
    localparam logic [2:0] ADDR_SCRATCH = 3'd3;
    localparam logic [2:0] ADDR_UP_LO   = 3'd4;
    localparam logic [2:0] ADDR_UP_HI   = 3'd5;
    localparam logic [2:0] ADDR_CTRL    = 3'd6;
    localparam logic [2:0] ADDR_CAPS    = 3'd7;

    localparam int CTRL_EN  = 0;
    localparam int CTRL_CLR = 1;

endpackage

// File: rtl/sysid_uptime_ctr.sv
// Free-running uptime counter with a coherent high-word snapshot.
// Ports:
//   clk       - system clock
//   reset_n   - asynchronous active-low reset
//   en        - count enable (holds when low)
//   clr       - one-cycle clear, wins over en
//   snap      - latch count[UPTIME_W-1:32] into shadow_hi at this edge
//   count     - live counter value
//   shadow_hi - upper counter bits captured by the last snap
module sysid_uptime_ctr #(
    parameter int UPTIME_W = 48
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                clr,
    input  logic                snap,
    output logic [UPTIME_W-1:0] count,
    output logic [UPTIME_W-33:0] shadow_hi
);

    localparam logic [UPTIME_W-1:0] ONE = 1;

    // The snapshot uses the pre-increment count, the same value the low
    // word read returns at this edge, so LO/HI pairs are always coherent
    // even across a carry out of bit 31.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count     <= '0;
            shadow_hi <= '0;
        end else begin
            if (snap) begin
                shadow_hi <= count[UPTIME_W-1:32];
            end
            if (clr) begin
                count <= '0;
            end else if (en) begin
                count <= count + ONE;
            end
        end
    end

endmodule

// File: rtl/sysid_regbank.sv
// System-identification register bank (Avalon-MM slave).
// Word map: 0 SYSTEM_ID, 1 TIMESTAMP, 2 VERSION, 3 SCRATCH (RW, byte lanes),
// 4 UPTIME_LO (read also snapshots the high bits), 5 UPTIME_HI (snapshot),
// 6 CONTROL (bit0 en, bit1 clr pulse), 7 CAPS.
// Ports:
//   clk, reset_n          - clock and asynchronous active-low reset
//   address, read, write  - Avalon word address and strobes
//   byteenable, writedata - write lanes and data
//   readdata              - registered read data, held between reads
//   readdatavalid         - one-cycle pulse, fixed latency of one clock
//   uptime                - live counter for local hardware timestamping
module sysid_regbank
    import sysid_pkg::*;
#(
    parameter logic [31:0] SYSTEM_ID = 32'h0000_55C7,
    parameter logic [31:0] TIMESTAMP = 32'h0000_0000,
    parameter logic [31:0] VERSION   = 32'h0001_0000,
    parameter logic [31:0] CAPS      = 32'h0000_0000,
    parameter int          UPTIME_W  = 48
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [2:0]          address,
    input  logic                read,
    input  logic                write,
    input  logic [3:0]          byteenable,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic                readdatavalid,
    output logic [UPTIME_W-1:0] uptime
);

    // The high-word snapshot path assumes at least one bit above 31 and at
    // most a 32-bit high word.
    generate
        if (UPTIME_W < 33 || UPTIME_W > 64) begin : g_bad_width
            $error("sysid_regbank: UPTIME_W must be in 33..64");
        end
    endgenerate

    logic [31:0]         scratch;
    logic                ctrl_en;
    logic [UPTIME_W-33:0] shadow_hi;
    logic [31:0]         hi_ext;
    logic [31:0]         rd_mux;
    logic                wr_ok;
    logic                ctr_clr;
    logic                ctr_snap;

    // A simultaneous read wins; the write is dropped entirely.
    assign wr_ok = write && !read;

    // CONTROL bits live in byte lane 0, so a clr only counts when that lane
    // is enabled.
    assign ctr_clr  = wr_ok && (address == ADDR_CTRL) && byteenable[0]
                      && writedata[CTRL_CLR];
    assign ctr_snap = read && (address == ADDR_UP_LO);

    sysid_uptime_ctr #(
        .UPTIME_W (UPTIME_W)
    ) u_ctr (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (ctrl_en),
        .clr       (ctr_clr),
        .snap      (ctr_snap),
        .count     (uptime),
        .shadow_hi (shadow_hi)
    );

    // Zero-extend the snapshot; written as a slice assignment so UPTIME_W
    // of 64 needs no zero-width replication.
    always_comb begin
        hi_ext                 = '0;
        hi_ext[UPTIME_W-33:0]  = shadow_hi;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_ID:      rd_mux = SYSTEM_ID;
            ADDR_TS:      rd_mux = TIMESTAMP;
            ADDR_VER:     rd_mux = VERSION;
            ADDR_SCRATCH: rd_mux = scratch;
            ADDR_UP_LO:   rd_mux = uptime[31:0];
            ADDR_UP_HI:   rd_mux = hi_ext;
            ADDR_CTRL:    rd_mux[CTRL_EN] = ctrl_en;
            ADDR_CAPS:    rd_mux = CAPS;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
            ctrl_en <= 1'b1;
        end else if (wr_ok) begin
            if (address == ADDR_SCRATCH) begin
                for (int i = 0; i < 4; i++) begin
                    if (byteenable[i]) begin
                        scratch[8*i +: 8] <= writedata[8*i +: 8];
                    end
                end
            end
            if (address == ADDR_CTRL && byteenable[0]) begin
                ctrl_en <= writedata[CTRL_EN];
            end
        end
    end

    // readdata only moves on an accepted read so it holds between pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) begin
                readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_sysid_regbank.sv
// Directed bench for sysid_regbank with default parameters (UPTIME_W = 48).
module tb_sysid_regbank;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [47:0] uptime;

    int checkCount;
    int errorCount;
    logic [47:0] frozen;

    sysid_regbank dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .address       (address),
        .read          (read),
        .write         (write),
        .byteenable    (byteenable),
        .writedata     (writedata),
        .readdata      (readdata),
        .readdatavalid (readdatavalid),
        .uptime        (uptime)
    );

    // 100 MHz clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drive one bus cycle, clock it, and return to idle 1ns after the edge
    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [2:0] addr, input logic [3:0] be,
                                 input logic [31:0] wdata);
        read       = rd;
        write      = wr;
        address    = addr;
        byteenable = be;
        writedata  = wdata;
        @(posedge clk);
        #1;
        read  = 1'b0;
        write = 1'b0;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Stimulus sequence
    initial begin
        checkCount = 0;
        errorCount = 0;
        reset_n    = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        idleCycle();
        idleCycle();
        checkOutput("reset_rdv", readdatavalid, 1'b0);
        checkOutput("reset_rdata", readdata, 32'h0);
        checkOutput("reset_uptime", uptime, 48'h0);
        reset_n = 1'b1;
        idleCycle();

        // Back-to-back ID reads
        applyStimulus(1, 0, 3'd0, 4'h0, 32'h0);
        checkOutput("rd_id_valid", readdatavalid, 1'b1);
        checkOutput("rd_id", readdata, 32'h0000_55C7);
        applyStimulus(1, 0, 3'd1, 4'h0, 32'h0);
        checkOutput("rd_ts_valid", readdatavalid, 1'b1);
        checkOutput("rd_ts", readdata, 32'h0);
        applyStimulus(1, 0, 3'd2, 4'h0, 32'h0);
        checkOutput("rd_ver_valid", readdatavalid, 1'b1);
        checkOutput("rd_ver", readdata, 32'h0001_0000);
        applyStimulus(1, 0, 3'd7, 4'h0, 32'h0);
        checkOutput("rd_caps_valid", readdatavalid, 1'b1);
        checkOutput("rd_caps", readdata, 32'h0);
        idleCycle();
        checkOutput("idle_rdv", readdatavalid, 1'b0);

        // Scratch byte lanes
        applyStimulus(0, 1, 3'd3, 4'hF, 32'hDEAD_BEEF);
        checkOutput("wr_no_rdv", readdatavalid, 1'b0);
        applyStimulus(1, 0, 3'd3, 4'h0, 32'h0);
        checkOutput("scratch_full", readdata, 32'hDEAD_BEEF);
        applyStimulus(0, 1, 3'd3, 4'b0101, 32'h1234_5678);
        applyStimulus(1, 0, 3'd3, 4'h0, 32'h0);
        checkOutput("scratch_lanes", readdata, 32'hDE34_BE78);
        idleCycle();
        checkOutput("rdata_hold", readdata, 32'hDE34_BE78);

        // Write to a read-only word is ignored
        applyStimulus(0, 1, 3'd0, 4'hF, 32'hFFFF_FFFF);
        applyStimulus(1, 0, 3'd0, 4'h0, 32'h0);
        checkOutput("ro_ignored", readdata, 32'h0000_55C7);

        // Coherent snapshot across a bit-31 carry
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h2);
        checkOutput("clr_zero", uptime, 48'h0);
        dut.u_ctr.count = 48'h0000_FFFF_FFFF;
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h1);
        checkOutput("preload_hold", uptime, 48'h0000_FFFF_FFFF);
        applyStimulus(1, 0, 3'd4, 4'h0, 32'h0);
        checkOutput("uplo", readdata, 32'hFFFF_FFFF);
        checkOutput("up_rolled", uptime, 48'h0001_0000_0000);
        applyStimulus(1, 0, 3'd5, 4'h0, 32'h0);
        checkOutput("uphi", readdata, 32'h0);
        applyStimulus(1, 0, 3'd5, 4'h0, 32'h0);
        checkOutput("uphi_no_resample", readdata, 32'h0);
        applyStimulus(1, 0, 3'd4, 4'h0, 32'h0);
        applyStimulus(1, 0, 3'd5, 4'h0, 32'h0);
        checkOutput("uphi_after_carry", readdata, 32'h1);

        // Full-width wrap
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h0);
        dut.u_ctr.count = 48'hFFFF_FFFF_FFFF;
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h1);
        checkOutput("wrap_hold", uptime, 48'hFFFF_FFFF_FFFF);
        idleCycle();
        checkOutput("wrap_zero", uptime, 48'h0);

        // Freeze, then clear with enable
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h0);
        frozen = uptime;
        for (int i = 0; i < 10; i++) idleCycle();
        checkOutput("freeze", uptime, frozen);
        checkOutput("freeze_nonzero", (frozen != 48'h0), 1'b1);
        applyStimulus(1, 0, 3'd6, 4'h0, 32'h0);
        checkOutput("ctrl_off", readdata, 32'h0);
        applyStimulus(0, 1, 3'd6, 4'hF, 32'h3);
        checkOutput("clr_now", uptime, 48'h0);
        idleCycle();
        checkOutput("clr_next", uptime, 48'h1);
        applyStimulus(1, 0, 3'd6, 4'h0, 32'h0);
        checkOutput("ctrl_rb", readdata, 32'h1);

        // Read and write together: read wins, write dropped
        applyStimulus(1, 1, 3'd3, 4'hF, 32'hFFFF_FFFF);
        checkOutput("rw_valid", readdatavalid, 1'b1);
        checkOutput("rw_old", readdata, 32'hDE34_BE78);
        applyStimulus(1, 0, 3'd3, 4'h0, 32'h0);
        checkOutput("rw_unchanged", readdata, 32'hDE34_BE78);

        // Reset in the same cycle as a read
        read    = 1'b1;
        address = 3'd3;
        reset_n = 1'b0;
        idleCycle();
        checkOutput("rst_rdv", readdatavalid, 1'b0);
        checkOutput("rst_rdata", readdata, 32'h0);
        checkOutput("rst_uptime", uptime, 48'h0);
        read    = 1'b0;
        reset_n = 1'b1;
        idleCycle();
        applyStimulus(1, 0, 3'd3, 4'h0, 32'h0);
        checkOutput("rst_scratch", readdata, 32'h0);
        applyStimulus(1, 0, 3'd6, 4'h0, 32'h0);
        checkOutput("rst_ctrl", readdata, 32'h1);
        applyStimulus(1, 0, 3'd5, 4'h0, 32'h0);
        checkOutput("rst_shadow", readdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
